sprite_port_arbiter: RTL and testbench
======================================

# sprite_port_arbiter

Shares one synchronous sprite-ROM read port between several pixel-pipeline requesters: PacMan, ghost, item and font lookups. Each requester presents an address with a valid/ready handshake. The arbiter grants one request per cycle using round-robin, with an optional fixed top priority for requester 0. It drives the ROM address, tracks each in-flight read through the ROM latency, and returns the read data tagged with the requester ID. It sits between the colour-mapper address generators and a single shared sprite RAM, replacing the per-sprite ROM instances.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 12, ROM address width
- DATA_W, 24, ROM word width (RGB888)
- ROM_LAT, 1, ROM read latency in cycles (1..3)
- PRIO0, 1, when 1 requester 0 always wins; when 0 it joins pure round-robin

Ports:
- Clk, in, 1, system clock; all logic on posedge
- Reset, in, 1, synchronous, active-low reset
- enable, in, 1, when 0 no new grants are made; in-flight reads complete
- req_valid, in, NUM_REQ, per-requester request
- req_addr, in, NUM_REQ x ADDR_W, per-requester address; must be held stable while valid and not ready
- req_ready, out, NUM_REQ, one-hot-or-zero grant (combinational)
- rom_rd, out, 1, registered read strobe
- rom_addr, out, ADDR_W, registered ROM address
- rom_data, in, DATA_W, ROM output, valid ROM_LAT cycles after rom_rd
- rsp_valid, out, 1, registered response strobe
- rsp_id, out, $clog2(NUM_REQ), requester index for rsp_data
- rsp_data, out, DATA_W, returned word
- busy, out, 1, high while any read is in flight or a response is pending

## Operation
- Grant logic:
  - If enable=0, req_ready = 0.
  - Else, if PRIO0=1 and req_valid[0]=1, grant requester 0.
  - Else, grant the first requester with valid=1, scanning from ptr upward with wrap at NUM_REQ.
- A request is accepted when req_valid[i] & req_ready[i]. On acceptance:
  - rom_addr <= req_addr[i], rom_rd <= 1.
  - The ID is pushed into the tag shift register.
  - ptr <= (i+1) mod NUM_REQ. A requester-0 win under PRIO0 does not move ptr.
- With no acceptance, rom_rd <= 0 and rom_addr holds its last value.
- Tag pipeline is a ROM_LAT+1 stage shift register of {valid, id}. Stage ROM_LAT aligns with rom_data. On the next edge:
  - rsp_valid <= that stage's valid.
  - rsp_id <= that stage's id.
  - rsp_data <= rom_data.
- Responses have no backpressure. Requesters must always accept rsp_valid.
- Controller state is derived from enable and the tag pipeline:
  - IDLE: pipeline empty. Grants are allowed when enable=1.
  - RUN: enable=1 and at least one read is in flight.
  - DRAIN: enable=0 and reads are in flight. No grants; returns to IDLE when the pipeline is empty.
- busy = (state != IDLE) | rsp_valid.
- Reset (Reset=0 at posedge):
  - ptr = 0, tag pipeline cleared, rom_rd = 0, rom_addr = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, state = IDLE.
  - In-flight reads are discarded with no response.
  - req_ready = 0 during the reset cycle.

## Timing
- Accept in cycle c → rom_rd/rom_addr in c+1 → rom_data in c+1+ROM_LAT → rsp_valid in c+2+ROM_LAT. With ROM_LAT=1, the response arrives 3 cycles after acceptance.
- Throughput: one accept per cycle, sustained indefinitely. Responses come back in acceptance order.
- enable falling in cycle c blocks acceptance in cycle c. Reads already accepted still return.
- Simultaneous requests: exactly one ready per cycle. The others wait with address held.
- ptr wraps from NUM_REQ-1 to 0.
- Overflow is impossible: the pipeline is fixed depth and needs no counter.

## Structure
- Shared package sprite_pkg holds:
  - the requester index constants REQ_PACMAN=0, REQ_GHOST=1, REQ_ITEMS=2, REQ_FONT=3;
  - the typedef rgb_t (24-bit);
  - the sprite base-offset constants (676 words per 26x26 sprite).
- One natural sub-module is rr_grant: a combinational round-robin picker with inputs valid vector and ptr, and outputs a one-hot grant and an index. The arbiter owns ptr, the tag pipeline and the output registers.

## Test plan
- Single request: req_valid=0001, addr 0x054, ROM word 0x47B7AE, ROM_LAT=1 → ready[0] same cycle; rom_addr=0x054 at c+1; rsp_valid, id=0, data 0x47B7AE at c+3; busy low at c+4.
- Round-robin fairness, PRIO0=0, all four valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses in the same order.
- Priority, PRIO0=1, all valid for 4 cycles, then req 0 drops → grants 0,0,0,0, then 1,2,3. Under PRIO0 grants, ptr stays at 0.
- Drain: accept on requesters 1 and 2 in back-to-back cycles, then enable=0 with all valid → no further ready; two responses arrive (ids 1, 2); busy falls the cycle after the last rsp_valid.
- Reset mid-flight: accept 3 back-to-back reads, assert Reset=0 one cycle later → no rsp_valid afterwards; all outputs zero; ptr=0. With Reset=1 and req_valid=0100, grant 2.
- ROM_LAT=3 build: back-to-back accepts on ids 3,0 → responses at c+5 and c+6 with the correct ids and data.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite-ROM definitions: requester indices, the RGB888 pixel type,
// the layout of the 26x26 sprites in the shared ROM and the arbiter states.
package sprite_pkg;

  localparam int REQ_PACMAN = 0;
  localparam int REQ_GHOST  = 1;
  localparam int REQ_ITEMS  = 2;
  localparam int REQ_FONT   = 3;

  typedef logic [23:0] rgb_t;

  localparam int SPRITE_W     = 26;
  localparam int SPRITE_H     = 26;
  localparam int SPRITE_WORDS = SPRITE_W * SPRITE_H;

  // Sprites are packed back to back in requester order.
  localparam int BASE_PACMAN = REQ_PACMAN * SPRITE_WORDS;
  localparam int BASE_GHOST  = REQ_GHOST  * SPRITE_WORDS;
  localparam int BASE_ITEMS  = REQ_ITEMS  * SPRITE_WORDS;
  localparam int BASE_FONT   = REQ_FONT   * SPRITE_WORDS;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RUN,
    ARB_DRAIN
  } arb_state_t;

  function automatic int sprite_base(input int req);
    return req * SPRITE_WORDS;
  endfunction

endpackage

// File: rtl/sprite_port_arbiter_rr_grant.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping at NUM_REQ, returned both one-hot and as an index.
module rr_grant
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       found
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/sprite_port_arbiter.sv
// Shares one synchronous sprite-ROM read port between the pixel-pipeline
// requesters; returns each word tagged with the requester that asked for it.
module sprite_port_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 24,
  parameter int ROM_LAT = 1,
  parameter int PRIO0   = 1
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             enable,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rom_rd,
  output logic [ADDR_W-1:0]                rom_addr,
  input  logic [DATA_W-1:0]                rom_data,
  output logic                             rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
  output logic [DATA_W-1:0]                rsp_data,
  output logic                             busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]               ptr;
  logic [NUM_REQ-1:0]             rr_onehot;
  logic [IDX_W-1:0]               rr_idx;
  logic                           rr_any;
  logic [IDX_W-1:0]               grant_idx;
  logic                           accept;
  logic                           prio_hit;
  logic [ROM_LAT:0]               tag_vld, tag_vld_nxt;
  logic [ROM_LAT:0][IDX_W-1:0]    tag_id, tag_id_nxt;
  logic                           in_flight_nxt;
  arb_state_t                     state, state_nxt;

  rr_grant #(.NUM_REQ(NUM_REQ)) u_rr_grant (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (rr_onehot),
    .idx   (rr_idx),
    .found (rr_any)
  );

  // Grants are suppressed while in reset so nothing is accepted on that edge.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    accept    = 1'b0;
    prio_hit  = 1'b0;
    if (enable && Reset) begin
      if ((PRIO0 != 0) && req_valid[REQ_PACMAN]) begin
        req_ready[REQ_PACMAN] = 1'b1;
        grant_idx             = IDX_W'(REQ_PACMAN);
        accept                = 1'b1;
        prio_hit              = 1'b1;
      end else if (rr_any) begin
        req_ready = rr_onehot;
        grant_idx = rr_idx;
        accept    = 1'b1;
      end
    end
  end

  assign tag_vld_nxt   = {tag_vld[ROM_LAT-1:0], accept};
  assign tag_id_nxt    = {tag_id[ROM_LAT-1:0], grant_idx};
  assign in_flight_nxt = |tag_vld_nxt;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ptr       <= '0;
      tag_vld   <= '0;
      tag_id    <= '0;
      rom_rd    <= 1'b0;
      rom_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      tag_vld   <= tag_vld_nxt;
      tag_id    <= tag_id_nxt;
      rom_rd    <= accept;
      rsp_valid <= tag_vld[ROM_LAT];
      if (accept) begin
        rom_addr <= req_addr[grant_idx];
        if (!prio_hit) begin
          if (grant_idx == IDX_W'(NUM_REQ - 1)) ptr <= '0;
          else                                  ptr <= grant_idx + 1'b1;
        end
      end
      if (tag_vld[ROM_LAT]) begin
        rsp_id   <= tag_id[ROM_LAT];
        rsp_data <= rom_data;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // State tracks whether the tag pipeline will hold reads after this edge.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (in_flight_nxt) state_nxt = ARB_RUN;
      ARB_RUN: begin
        if (!in_flight_nxt) state_nxt = ARB_IDLE;
        else if (!enable)   state_nxt = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (!in_flight_nxt) state_nxt = ARB_IDLE;
        else if (enable)    state_nxt = ARB_RUN;
      end
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  assign busy = (state != ARB_IDLE) | rsp_valid;

endmodule

// File: tb/tb_sprite_port_arbiter.sv
// Directed bench: three arbiter builds (priority, pure round-robin, 3-cycle ROM)
// share the request inputs, each with its own behavioural ROM.
module tb_sprite_port_arbiter;
  import sprite_pkg::*;

  logic            Clk;
  logic            Reset;
  logic            enable;
  logic [3:0]      req_valid;
  logic [3:0][11:0] req_addr;

  logic [3:0]  p_ready,  rr_ready,  l3_ready;
  logic        p_rd,     rr_rd,     l3_rd;
  logic [11:0] p_addr,   rr_addr,   l3_addr;
  rgb_t        p_rom,    rr_rom,    l3_rom;
  logic        p_rv,     rr_rv,     l3_rv;
  logic [1:0]  p_rid,    rr_rid,    l3_rid;
  rgb_t        p_rdat,   rr_rdat,   l3_rdat;
  logic        p_busy,   rr_busy,   l3_busy;
  rgb_t        l3_s1, l3_s2;

  int total = 0;
  int bad   = 0;

  sprite_port_arbiter #(.NUM_REQ(4), .ADDR_W(12), .DATA_W(24), .ROM_LAT(1), .PRIO0(1)) dut_p (
    .Clk(Clk), .Reset(Reset), .enable(enable), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(p_ready), .rom_rd(p_rd), .rom_addr(p_addr), .rom_data(p_rom),
    .rsp_valid(p_rv), .rsp_id(p_rid), .rsp_data(p_rdat), .busy(p_busy));

  sprite_port_arbiter #(.NUM_REQ(4), .ADDR_W(12), .DATA_W(24), .ROM_LAT(1), .PRIO0(0)) dut_rr (
    .Clk(Clk), .Reset(Reset), .enable(enable), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rr_ready), .rom_rd(rr_rd), .rom_addr(rr_addr), .rom_data(rr_rom),
    .rsp_valid(rr_rv), .rsp_id(rr_rid), .rsp_data(rr_rdat), .busy(rr_busy));

  sprite_port_arbiter #(.NUM_REQ(4), .ADDR_W(12), .DATA_W(24), .ROM_LAT(3), .PRIO0(0)) dut_l3 (
    .Clk(Clk), .Reset(Reset), .enable(enable), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(l3_ready), .rom_rd(l3_rd), .rom_addr(l3_addr), .rom_data(l3_rom),
    .rsp_valid(l3_rv), .rsp_id(l3_rid), .rsp_data(l3_rdat), .busy(l3_busy));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic rgb_t rom_word(input logic [11:0] a);
    if (a == 12'h054) return 24'h47B7AE;
    return {a ^ 12'h5A3, ~a};
  endfunction

  // ROM models drive junk when not read so a misaligned capture shows up.
  always @(posedge Clk) begin
    p_rom  <= p_rd  ? rom_word(p_addr)  : 24'hDEAD00;
    rr_rom <= rr_rd ? rom_word(rr_addr) : 24'hDEAD00;
    l3_s1  <= l3_rd ? rom_word(l3_addr) : 24'hDEAD00;
    l3_s2  <= l3_s1;
    l3_rom <= l3_s2;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset     = 1'b0;
    enable    = 1'b0;
    req_valid = 4'b0000;
    step();
    step();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset     = 1'b0;
    enable    = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) req_addr[i] = 12'h100 + 12'(i);
    step();
    step();
    #1;
    total++; if (p_ready  !== 4'b0000) begin bad++; $display("[TB] FAIL reset_p_ready got=%b exp=0000", p_ready); end
    total++; if (rr_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_rr_ready got=%b exp=0000", rr_ready); end
    total++; if (l3_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_l3_ready got=%b exp=0000", l3_ready); end
    total++; if (p_rd !== 1'b0 || p_addr !== 12'h000) begin bad++; $display("[TB] FAIL reset_rom got rd=%b addr=%h exp rd=0 addr=000", p_rd, p_addr); end
    total++; if (p_rv !== 1'b0 || p_rid !== 2'd0 || p_rdat !== 24'h0) begin bad++; $display("[TB] FAIL reset_rsp got v=%b id=%0d d=%h exp 0/0/0", p_rv, p_rid, p_rdat); end
    total++; if (p_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", p_busy); end
    Reset     = 1'b1;
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_single();
    apply_reset();
    enable      = 1'b1;
    req_addr[0] = 12'h054;
    req_valid   = 4'b0001;
    #1;
    total++; if (p_ready !== 4'b0001) begin bad++; $display("[TB] FAIL single_ready got=%b exp=0001", p_ready); end
    total++; if (p_busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_c got=%b exp=0", p_busy); end
    step();
    req_valid = 4'b0000;
    total++; if (p_rd !== 1'b1 || p_addr !== 12'h054) begin bad++; $display("[TB] FAIL single_rom got rd=%b addr=%h exp rd=1 addr=054", p_rd, p_addr); end
    total++; if (p_busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_c1 got=%b exp=1", p_busy); end
    step();
    total++; if (p_rv !== 1'b0) begin bad++; $display("[TB] FAIL single_early_rsp got=%b exp=0", p_rv); end
    step();
    total++; if (p_rv !== 1'b1 || p_rid !== 2'd0 || p_rdat !== 24'h47B7AE) begin bad++; $display("[TB] FAIL single_rsp got v=%b id=%0d d=%h exp 1/0/47b7ae", p_rv, p_rid, p_rdat); end
    step();
    total++; if (p_busy !== 1'b0 || p_rv !== 1'b0) begin bad++; $display("[TB] FAIL single_idle got busy=%b v=%b exp 0/0", p_busy, p_rv); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    int id;
    apply_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) req_addr[i] = 12'h100 + 12'(i);
    for (int k = 0; k < 11; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      exp_ready = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      total++; if (rr_ready !== exp_ready) begin bad++; $display("[TB] FAIL rr_ready[%0d] got=%b exp=%b", k, rr_ready, exp_ready); end
      if (k >= 3) begin
        id = (k - 3) % 4;
        total++;
        if (rr_rv !== 1'b1 || rr_rid !== 2'(id) || rr_rdat !== rom_word(12'h100 + 12'(id))) begin
          bad++;
          $display("[TB] FAIL rr_rsp[%0d] got v=%b id=%0d d=%h exp 1/%0d/%h", k, rr_rv, rr_rid, rr_rdat, id, rom_word(12'h100 + 12'(id)));
        end
      end
      step();
    end
    total++; if (rr_rv !== 1'b0) begin bad++; $display("[TB] FAIL rr_tail got v=%b exp=0", rr_rv); end
  endtask

  task automatic test_priority();
    logic [3:0] pv [13];
    logic [3:0] pe [13];
    // Tail entries park ptr at 3 before the PRIO0 wins to show they leave it alone.
    pv = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'h4, 4'hF, 4'hF, 4'hE, 4'hE, 4'hE};
    pe = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h1, 4'h1, 4'h8, 4'h2, 4'h4};
    apply_reset();
    enable = 1'b1;
    for (int k = 0; k < 13; k++) begin
      req_valid = pv[k];
      #1;
      total++; if (p_ready !== pe[k]) begin bad++; $display("[TB] FAIL prio_ready[%0d] got=%b exp=%b", k, p_ready, pe[k]); end
      step();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_drain();
    apply_reset();
    enable    = 1'b1;
    req_valid = 4'b0010;
    #1;
    total++; if (rr_ready !== 4'b0010) begin bad++; $display("[TB] FAIL drain_ready1 got=%b exp=0010", rr_ready); end
    step();
    req_valid = 4'b0100;
    #1;
    total++; if (rr_ready !== 4'b0100) begin bad++; $display("[TB] FAIL drain_ready2 got=%b exp=0100", rr_ready); end
    total++; if (rr_rd !== 1'b1 || rr_addr !== 12'h101) begin bad++; $display("[TB] FAIL drain_rom1 got rd=%b addr=%h exp 1/101", rr_rd, rr_addr); end
    step();
    enable    = 1'b0;
    req_valid = 4'b1111;
    #1;
    total++; if (rr_ready !== 4'b0000) begin bad++; $display("[TB] FAIL drain_block got=%b exp=0000", rr_ready); end
    total++; if (rr_addr !== 12'h102 || rr_busy !== 1'b1) begin bad++; $display("[TB] FAIL drain_rom2 got addr=%h busy=%b exp 102/1", rr_addr, rr_busy); end
    step();
    total++; if (rr_ready !== 4'b0000 || rr_rd !== 1'b0) begin bad++; $display("[TB] FAIL drain_hold got ready=%b rd=%b exp 0000/0", rr_ready, rr_rd); end
    total++; if (rr_rv !== 1'b1 || rr_rid !== 2'd1 || rr_rdat !== rom_word(12'h101)) begin bad++; $display("[TB] FAIL drain_rsp1 got v=%b id=%0d d=%h exp 1/1/%h", rr_rv, rr_rid, rr_rdat, rom_word(12'h101)); end
    step();
    total++; if (rr_rv !== 1'b1 || rr_rid !== 2'd2 || rr_rdat !== rom_word(12'h102)) begin bad++; $display("[TB] FAIL drain_rsp2 got v=%b id=%0d d=%h exp 1/2/%h", rr_rv, rr_rid, rr_rdat, rom_word(12'h102)); end
    total++; if (rr_busy !== 1'b1) begin bad++; $display("[TB] FAIL drain_busy_last got=%b exp=1", rr_busy); end
    step();
    total++; if (rr_busy !== 1'b0 || rr_rv !== 1'b0 || rr_ready !== 4'b0000) begin bad++; $display("[TB] FAIL drain_done got busy=%b v=%b ready=%b exp 0/0/0000", rr_busy, rr_rv, rr_ready); end
    req_valid = 4'b0000;
    enable    = 1'b1;
  endtask

  task automatic test_reset_midflight();
    logic [3:0] exp_ready;
    apply_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) req_addr[i] = 12'h100 + 12'(i);
    req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      #1;
      exp_ready = 4'b0001 << k;
      total++; if (rr_ready !== exp_ready) begin bad++; $display("[TB] FAIL mid_ready[%0d] got=%b exp=%b", k, rr_ready, exp_ready); end
      step();
    end
    Reset = 1'b0;
    #1;
    total++; if (rr_ready !== 4'b0000) begin bad++; $display("[TB] FAIL mid_ready_in_reset got=%b exp=0000", rr_ready); end
    step();
    Reset     = 1'b1;
    req_valid = 4'b1010;
    #1;
    total++; if (rr_rd !== 1'b0 || rr_addr !== 12'h000) begin bad++; $display("[TB] FAIL mid_rom_zero got rd=%b addr=%h exp 0/000", rr_rd, rr_addr); end
    total++; if (rr_rv !== 1'b0 || rr_rid !== 2'd0 || rr_rdat !== 24'h0 || rr_busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_rsp_zero got v=%b id=%0d d=%h busy=%b exp all 0", rr_rv, rr_rid, rr_rdat, rr_busy); end
    total++; if (rr_ready !== 4'b0010) begin bad++; $display("[TB] FAIL mid_ptr_zero got=%b exp=0010", rr_ready); end
    step();
    req_valid = 4'b0100;
    #1;
    total++; if (rr_ready !== 4'b0100 || rr_rv !== 1'b0) begin bad++; $display("[TB] FAIL mid_grant2 got ready=%b v=%b exp 0100/0", rr_ready, rr_rv); end
    step();
    req_valid = 4'b0000;
    total++; if (rr_rv !== 1'b0) begin bad++; $display("[TB] FAIL mid_no_stale got v=%b exp=0", rr_rv); end
    step();
    total++; if (rr_rv !== 1'b1 || rr_rid !== 2'd1) begin bad++; $display("[TB] FAIL mid_new_rsp1 got v=%b id=%0d exp 1/1", rr_rv, rr_rid); end
    step();
    total++; if (rr_rv !== 1'b1 || rr_rid !== 2'd2) begin bad++; $display("[TB] FAIL mid_new_rsp2 got v=%b id=%0d exp 1/2", rr_rv, rr_rid); end
    step();
  endtask

  task automatic test_lat3();
    apply_reset();
    enable      = 1'b1;
    req_addr[3] = 12'h2A0;
    req_addr[0] = 12'h031;
    req_valid   = 4'b1000;
    #1;
    total++; if (l3_ready !== 4'b1000) begin bad++; $display("[TB] FAIL l3_ready3 got=%b exp=1000", l3_ready); end
    step();
    req_valid = 4'b0001;
    #1;
    total++; if (l3_ready !== 4'b0001) begin bad++; $display("[TB] FAIL l3_ready0 got=%b exp=0001", l3_ready); end
    step();
    req_valid = 4'b0000;
    step();
    step();
    total++; if (l3_rv !== 1'b0 || l3_busy !== 1'b1) begin bad++; $display("[TB] FAIL l3_wait got v=%b busy=%b exp 0/1", l3_rv, l3_busy); end
    step();
    total++; if (l3_rv !== 1'b1 || l3_rid !== 2'd3 || l3_rdat !== rom_word(12'h2A0)) begin bad++; $display("[TB] FAIL l3_rsp3 got v=%b id=%0d d=%h exp 1/3/%h", l3_rv, l3_rid, l3_rdat, rom_word(12'h2A0)); end
    step();
    total++; if (l3_rv !== 1'b1 || l3_rid !== 2'd0 || l3_rdat !== rom_word(12'h031)) begin bad++; $display("[TB] FAIL l3_rsp0 got v=%b id=%0d d=%h exp 1/0/%h", l3_rv, l3_rid, l3_rdat, rom_word(12'h031)); end
    step();
    total++; if (l3_rv !== 1'b0 || l3_busy !== 1'b0) begin bad++; $display("[TB] FAIL l3_idle got v=%b busy=%b exp 0/0", l3_rv, l3_busy); end
  endtask

  initial begin
    Reset     = 1'b0;
    enable    = 1'b0;
    req_valid = 4'b0000;
    req_addr  = '0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_drain();
    test_reset_midflight();
    test_lat3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
